// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns EX/MEM load/store fields into a req/ack memory transaction and stalls the pipeline meanwhile.
// Optional WAIT abort timer is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] RData_o,
    output logic              RData_valid_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_access;
    logic              w_expire;

    if (TIMEOUT < 1) begin : g_badTimeout
        $error("mem_access_ctrl: TIMEOUT must be at least 1");
    end

    assign w_access = start_i & (MemRead_i | MemWrite_i);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_timeout;

    // An ack in the limit cycle is a normal completion, so it masks the abort.
    assign w_cntNext = r_cnt + CNT_W'(1);
    assign w_expire  = (r_state == ST_WAIT) && !mem_ack_i && (w_cntNext == CNT_W'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !mem_ack_i) begin
                r_cnt <= w_cntNext;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // DONE always falls back to IDLE so a held instruction is never serviced twice.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_access) w_nextState = ST_WAIT;
            ST_WAIT: if (mem_ack_i || w_expire) w_nextState = ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_i;
                        r_addr  <= Addr_i;
                        r_wdata <= WData_i;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        r_req <= 1'b0;
                        if (!r_we) r_rdata <= mem_rdata_i;
                    end else if (w_expire) begin
                        r_req <= 1'b0;
                        if (!r_we) r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_o       = ((r_state == ST_IDLE) && w_access) || (r_state == ST_WAIT);
        RData_valid_o = (r_state == ST_DONE) && !r_we;
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign RData_o     = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the timeout scenario follows MEM_TIMEOUT_EN.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WData_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] RData_o;
    logic        RData_valid_o;
    logic        timeout_o;

    int checks = 0;
    int passes = 0;
    int reqRises = 0;
    logic reqPrev = 1'b0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Addr_i(Addr_i), .WData_i(WData_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .RData_o(RData_o),
        .RData_valid_o(RData_valid_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts distinct requests so duplicated service shows up as an extra rise.
    always @(negedge clk_i) begin
        if (mem_req_o && !reqPrev) reqRises = reqRises + 1;
        reqPrev = mem_req_o;
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic start);
        MemRead_i  = rd;
        MemWrite_i = wr;
        Addr_i     = addr;
        WData_i    = wdata;
        start_i    = start;
    endtask

    task automatic nextCycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk_i);
        #2;
        checks++;
        if ({mem_req_o, mem_we_o, stall_o, RData_valid_o, timeout_o} !== 5'b0)
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {mem_req_o, mem_we_o, stall_o, RData_valid_o, timeout_o});
        else passes++;
        checks++;
        if ({mem_addr_o, mem_wdata_o, RData_o} !== 96'b0)
            $display("[TB] FAIL reset_data: addr %h wdata %h rdata %h expected all 0",
                     mem_addr_o, mem_wdata_o, RData_o);
        else passes++;
        rst_i = 1'b1;
    endtask

    task automatic test_load_immediate;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'h10, '0, 1'b1); #1;
        checks++;
        if ({stall_o, mem_req_o} !== 2'b10)
            $display("[TB] FAIL load_issue: stall/req %b expected 10", {stall_o, mem_req_o});
        else passes++;
        nextCycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
        checks++;
        if ({stall_o, mem_req_o, mem_we_o} !== 3'b110 || mem_addr_o !== 32'h10)
            $display("[TB] FAIL load_wait: stall/req/we %b addr %h expected 110 addr 00000010",
                     {stall_o, mem_req_o, mem_we_o}, mem_addr_o);
        else passes++;
        nextCycle(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        checks++;
        if ({stall_o, mem_req_o, RData_valid_o} !== 3'b001 || RData_o !== 32'hDEADBEEF)
            $display("[TB] FAIL load_done: stall/req/valid %b rdata %h expected 001 deadbeef",
                     {stall_o, mem_req_o, RData_valid_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
        checks++;
        if ({stall_o, mem_req_o, RData_valid_o} !== 3'b000 || RData_o !== 32'hDEADBEEF)
            $display("[TB] FAIL load_after: stall/req/valid %b rdata %h expected 000 deadbeef",
                     {stall_o, mem_req_o, RData_valid_o}, RData_o);
        else passes++;
    endtask

    task automatic test_store_wait;
        nextCycle(); applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1); #1;
        checks++;
        if (stall_o !== 1'b1)
            $display("[TB] FAIL store_issue: stall %b expected 1", stall_o);
        else passes++;
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            Addr_i  = 32'hFFFF0000 + k;
            WData_i = 32'h0F0F0000 + k;
            if (k == 5) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'h0BAD0BAD;
            end
            #1;
            checks++;
            if ({stall_o, mem_req_o, mem_we_o} !== 3'b111 || mem_addr_o !== 32'h20 ||
                mem_wdata_o !== 32'h12345678)
                $display("[TB] FAIL store_hold%0d: stall/req/we %b addr %h wdata %h expected 111 00000020 12345678",
                         k, {stall_o, mem_req_o, mem_we_o}, mem_addr_o, mem_wdata_o);
            else passes++;
        end
        nextCycle(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        checks++;
        if ({stall_o, mem_req_o, RData_valid_o} !== 3'b000 || RData_o !== 32'hDEADBEEF)
            $display("[TB] FAIL store_done: stall/req/valid %b rdata %h expected 000 deadbeef",
                     {stall_o, mem_req_o, RData_valid_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
    endtask

    task automatic test_read_write_both;
        nextCycle(); applyStimulus(1'b1, 1'b1, 32'hC0, 32'hA5A5A5A5, 1'b1); #1;
        nextCycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777; #1;
        checks++;
        if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hA5A5A5A5)
            $display("[TB] FAIL both_we: we %b wdata %h expected 1 a5a5a5a5", mem_we_o, mem_wdata_o);
        else passes++;
        nextCycle(); mem_ack_i = 1'b0; #1;
        checks++;
        if (RData_valid_o !== 1'b0 || RData_o !== 32'hDEADBEEF)
            $display("[TB] FAIL both_done: valid %b rdata %h expected 0 deadbeef", RData_valid_o, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
    endtask

    task automatic test_back_to_back;
        int startRises;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'h40, '0, 1'b1); #1;
        startRises = reqRises;
        nextCycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111; #1;
        nextCycle(); mem_ack_i = 1'b0; #1;
        checks++;
        if ({stall_o, RData_valid_o} !== 2'b01 || RData_o !== 32'h11111111)
            $display("[TB] FAIL b2b_done1: stall/valid %b rdata %h expected 01 11111111",
                     {stall_o, RData_valid_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'h44, '0, 1'b1); #1;
        checks++;
        if ({stall_o, mem_req_o} !== 2'b10)
            $display("[TB] FAIL b2b_issue2: stall/req %b expected 10", {stall_o, mem_req_o});
        else passes++;
        nextCycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222; #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h44)
            $display("[TB] FAIL b2b_wait2: req %b addr %h expected 1 00000044", mem_req_o, mem_addr_o);
        else passes++;
        nextCycle(); mem_ack_i = 1'b0; #1;
        checks++;
        if (RData_valid_o !== 1'b1 || RData_o !== 32'h22222222)
            $display("[TB] FAIL b2b_done2: valid %b rdata %h expected 1 22222222", RData_valid_o, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
        checks++;
        if (reqRises - startRises !== 2 || mem_req_o !== 1'b0)
            $display("[TB] FAIL b2b_count: requests %0d req %b expected 2 0", reqRises - startRises, mem_req_o);
        else passes++;
    endtask

    task automatic test_start_drop;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'h80, '0, 1'b1); #1;
        for (int c = 1; c <= 3; c++) begin
            nextCycle(); start_i = 1'b0; #1;
            checks++;
            if ({stall_o, mem_req_o} !== 2'b11)
                $display("[TB] FAIL drop_wait%0d: stall/req %b expected 11", c, {stall_o, mem_req_o});
            else passes++;
        end
        nextCycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE0001; #1;
        nextCycle(); mem_ack_i = 1'b0; #1;
        checks++;
        if ({stall_o, RData_valid_o} !== 2'b01 || RData_o !== 32'hCAFE0001)
            $display("[TB] FAIL drop_done: stall/valid %b rdata %h expected 01 cafe0001",
                     {stall_o, RData_valid_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'h90, '0, 1'b0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999; #1;
        checks++;
        if ({stall_o, mem_req_o} !== 2'b00)
            $display("[TB] FAIL nostart_idle: stall/req %b expected 00", {stall_o, mem_req_o});
        else passes++;
        nextCycle(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        checks++;
        if ({stall_o, mem_req_o, RData_valid_o} !== 3'b000 || RData_o !== 32'hCAFE0001)
            $display("[TB] FAIL idle_ack: stall/req/valid %b rdata %h expected 000 cafe0001",
                     {stall_o, mem_req_o, RData_valid_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
    endtask

    task automatic test_timeout;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'hB0, '0, 1'b1); #1;
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            nextCycle(); #1;
            checks++;
            if ({mem_req_o, timeout_o} !== 2'b10)
                $display("[TB] FAIL to_wait%0d: req/timeout %b expected 10", c, {mem_req_o, timeout_o});
            else passes++;
        end
        nextCycle(); #1;
        checks++;
        if ({stall_o, mem_req_o, timeout_o} !== 3'b001 || RData_o !== 32'h0)
            $display("[TB] FAIL to_abort: stall/req/timeout %b rdata %h expected 001 00000000",
                     {stall_o, mem_req_o, timeout_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
        checks++;
        if ({stall_o, timeout_o} !== 2'b01)
            $display("[TB] FAIL to_sticky: stall/timeout %b expected 01", {stall_o, timeout_o});
        else passes++;
`else
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            if (c == 10) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'h5A5A5A5A;
            end
            #1;
            checks++;
            if ({stall_o, mem_req_o, timeout_o} !== 3'b110)
                $display("[TB] FAIL long_wait%0d: stall/req/timeout %b expected 110",
                         c, {stall_o, mem_req_o, timeout_o});
            else passes++;
        end
        nextCycle(); mem_ack_i = 1'b0; #1;
        checks++;
        if ({RData_valid_o, timeout_o} !== 2'b10 || RData_o !== 32'h5A5A5A5A)
            $display("[TB] FAIL long_done: valid/timeout %b rdata %h expected 10 5a5a5a5a",
                     {RData_valid_o, timeout_o}, RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
`endif
    endtask

    task automatic test_reset_in_wait;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'hA0, '0, 1'b1); #1;
        nextCycle(); #1;
        checks++;
        if (mem_req_o !== 1'b1)
            $display("[TB] FAIL rstw_pre: req %b expected 1", mem_req_o);
        else passes++;
        nextCycle(); rst_i = 1'b0; applyStimulus(1'b0, 1'b0, '0, '0, 1'b0); #1;
        nextCycle(); #1;
        checks++;
        if ({mem_req_o, stall_o, RData_valid_o, timeout_o, mem_we_o} !== 5'b0 ||
            RData_o !== 32'h0 || mem_addr_o !== 32'h0)
            $display("[TB] FAIL rstw_clear: req/stall/valid/timeout/we %b rdata %h addr %h expected 00000 0 0",
                     {mem_req_o, stall_o, RData_valid_o, timeout_o, mem_we_o}, RData_o, mem_addr_o);
        else passes++;
        rst_i = 1'b1;
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'hA4, '0, 1'b1); #1;
        checks++;
        if ({stall_o, mem_req_o} !== 2'b10)
            $display("[TB] FAIL rstw_idle: stall/req %b expected 10", {stall_o, mem_req_o});
        else passes++;
        nextCycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h13579BDF; #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hA4)
            $display("[TB] FAIL rstw_req: req %b addr %h expected 1 000000a4", mem_req_o, mem_addr_o);
        else passes++;
        nextCycle(); mem_ack_i = 1'b0; #1;
        checks++;
        if (RData_o !== 32'h13579BDF)
            $display("[TB] FAIL rstw_data: rdata %h expected 13579bdf", RData_o);
        else passes++;
        nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, 1'b1); #1;
    endtask

    initial begin
        test_reset();
        test_load_immediate();
        test_store_wait();
        test_read_write_both();
        test_back_to_back();
        test_start_drop();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
